// File: rtl/cache_ro_ctrl.sv
// rtl/cache_ro_ctrl.sv - N-way set-associative read-only block cache with SDRAM miss path
//
// Ports:
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_s_read, i_s_addr               slave block-read request and block address
//   o_s_waitrequest                  slave stall (combinational)
//   o_s_readdata, o_s_readdatavalid  returned block and its one-cycle qualifier
//   o_m_read, o_m_addr               SDRAM read request and byte address
//   i_m_waitrequest                  SDRAM stall
//   i_m_readdata, i_m_readdatavalid  SDRAM returned block and its qualifier
//   i_flush                          invalidate all lines
//   o_busy                           controller is not idle
//   o_hit_cnt, o_miss_cnt            saturating statistics counters
module cache_ro_ctrl #(
   parameter int SIZE_BLOCK = 32,
   parameter int BIT_TOTAL  = 24,
   parameter int BIT_INDEX  = 8,
   parameter int WAY        = 4,
   parameter int CNT_W      = 16,
   localparam int OFS       = $clog2(SIZE_BLOCK / 8)
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_s_read,
   input  logic [BIT_TOTAL-1:0]     i_s_addr,
   output logic                     o_s_waitrequest,
   output logic [SIZE_BLOCK-1:0]    o_s_readdata,
   output logic                     o_s_readdatavalid,
   output logic                     o_m_read,
   output logic [BIT_TOTAL+OFS-1:0] o_m_addr,
   input  logic                     i_m_waitrequest,
   input  logic [SIZE_BLOCK-1:0]    i_m_readdata,
   input  logic                     i_m_readdatavalid,
   input  logic                     i_flush,
   output logic                     o_busy,
   output logic [CNT_W-1:0]         o_hit_cnt,
   output logic [CNT_W-1:0]         o_miss_cnt
);

   localparam int BIT_TAG = BIT_TOTAL - BIT_INDEX;
   localparam int SETS    = 1 << BIT_INDEX;
   localparam int WAY_W   = (WAY > 1) ? $clog2(WAY) : 1;

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_MISS_REQ  = 2'd1;
   localparam logic [1:0] S_MISS_WAIT = 2'd2;
   localparam logic [1:0] S_FLUSH     = 2'd3;

   logic [1:0]            state;
   logic                  flush_pend;
   logic [BIT_INDEX-1:0]  flush_idx;
   logic [BIT_TOTAL-1:0]  miss_addr;

   // valid[set] holds one bit per way so a whole set clears in one write
   logic [WAY-1:0]        valid    [SETS];
   logic [WAY_W-1:0]      rr_ptr   [SETS];
   logic [BIT_TAG-1:0]    tag_mem  [WAY][SETS];
   logic [SIZE_BLOCK-1:0] data_mem [WAY][SETS];

   logic [BIT_INDEX-1:0]  req_idx;
   logic [BIT_TAG-1:0]    req_tag;
   logic [BIT_INDEX-1:0]  miss_idx;
   logic [BIT_TAG-1:0]    miss_tag;
   logic                  hit;
   logic [SIZE_BLOCK-1:0] hit_data;
   logic [WAY_W-1:0]      victim;
   logic                  victim_invalid;
   logic                  fill;

   assign o_s_waitrequest = i_rst | (state != S_IDLE) | i_flush;
   assign o_busy          = (state != S_IDLE);

   assign req_idx  = i_s_addr[BIT_INDEX-1:0];
   assign req_tag  = i_s_addr[BIT_TOTAL-1:BIT_INDEX];
   assign miss_idx = miss_addr[BIT_INDEX-1:0];
   assign miss_tag = miss_addr[BIT_TOTAL-1:BIT_INDEX];
   assign fill     = (state == S_MISS_WAIT) & i_m_readdatavalid;

   // At most one way can match, so the last-match-wins loop is unambiguous
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      for (int w = 0; w < WAY; w++) begin
         if (valid[req_idx][w] && (tag_mem[w][req_idx] == req_tag)) begin
            hit      = 1'b1;
            hit_data = data_mem[w][req_idx];
         end
      end
   end

   // Scan downwards so the lowest-index invalid way is the one left selected
   always_comb begin
      victim         = rr_ptr[miss_idx];
      victim_invalid = 1'b0;
      for (int w = WAY - 1; w >= 0; w--) begin
         if (!valid[miss_idx][w]) begin
            victim         = WAY_W'(w);
            victim_invalid = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state             <= S_IDLE;
         flush_pend        <= 1'b0;
         flush_idx         <= '0;
         miss_addr         <= '0;
         o_m_read          <= 1'b0;
         o_m_addr          <= '0;
         o_s_readdata      <= '0;
         o_s_readdatavalid <= 1'b0;
         o_hit_cnt         <= '0;
         o_miss_cnt        <= '0;
      end else begin
         o_s_readdatavalid <= 1'b0;
         case (state)
            S_IDLE: begin
               // flush wins over a simultaneous read; the read stays stalled
               if (i_flush) begin
                  state     <= S_FLUSH;
                  flush_idx <= '0;
               end else if (i_s_read) begin
                  if (hit) begin
                     o_s_readdata      <= hit_data;
                     o_s_readdatavalid <= 1'b1;
                     if (o_hit_cnt != '1) o_hit_cnt <= o_hit_cnt + 1'b1;
                  end else begin
                     miss_addr <= i_s_addr;
                     o_m_addr  <= (BIT_TOTAL+OFS)'(i_s_addr) << OFS;
                     o_m_read  <= 1'b1;
                     state     <= S_MISS_REQ;
                     if (o_miss_cnt != '1) o_miss_cnt <= o_miss_cnt + 1'b1;
                  end
               end
            end
            S_MISS_REQ: begin
               if (i_flush) flush_pend <= 1'b1;
               if (!i_m_waitrequest) begin
                  o_m_read <= 1'b0;
                  state    <= S_MISS_WAIT;
               end
            end
            S_MISS_WAIT: begin
               if (i_m_readdatavalid) begin
                  o_s_readdata      <= i_m_readdata;
                  o_s_readdatavalid <= 1'b1;
                  // a flush requested during the miss runs right after it
                  if (flush_pend || i_flush) begin
                     state      <= S_FLUSH;
                     flush_idx  <= '0;
                     flush_pend <= 1'b0;
                  end else begin
                     state <= S_IDLE;
                  end
               end else if (i_flush) begin
                  flush_pend <= 1'b1;
               end
            end
            S_FLUSH: begin
               flush_idx <= flush_idx + 1'b1;
               if (flush_idx == {BIT_INDEX{1'b1}}) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int s = 0; s < SETS; s++) begin
            valid[s]  <= '0;
            rr_ptr[s] <= '0;
         end
      end else if (state == S_FLUSH) begin
         valid[flush_idx]  <= '0;
         rr_ptr[flush_idx] <= '0;
      end else if (fill) begin
         valid[miss_idx][victim] <= 1'b1;
         // the pointer only advances when a valid line is actually evicted
         if (!victim_invalid) begin
            if (rr_ptr[miss_idx] == WAY_W'(WAY - 1)) rr_ptr[miss_idx] <= '0;
            else rr_ptr[miss_idx] <= rr_ptr[miss_idx] + 1'b1;
         end
      end
   end

   // Tag and data arrays carry no reset; valid bits alone gate their use
   always_ff @(posedge i_clk) begin
      if (fill && !i_rst) begin
         tag_mem[victim][miss_idx]  <= miss_tag;
         data_mem[victim][miss_idx] <= i_m_readdata;
      end
   end

endmodule

// File: tb/tb_cache_ro_ctrl.sv
// tb/tb_cache_ro_ctrl.sv - directed self-checking bench for cache_ro_ctrl
module tb_cache_ro_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_read;
   logic [23:0] s_addr;
   logic        s_waitrequest;
   logic [31:0] s_readdata;
   logic        s_readdatavalid;
   logic        m_read;
   logic [25:0] m_addr;
   logic        m_waitrequest;
   logic [31:0] m_readdata;
   logic        m_readdatavalid;
   logic        flush;
   logic        busy;
   logic [3:0]  hit_cnt;
   logic [3:0]  miss_cnt;

   int errors = 0;
   int checks = 0;
   int m_reads = 0;

   cache_ro_ctrl #(
      .SIZE_BLOCK(32), .BIT_TOTAL(24), .BIT_INDEX(8), .WAY(4), .CNT_W(4)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_s_read(s_read),
      .i_s_addr(s_addr),
      .o_s_waitrequest(s_waitrequest),
      .o_s_readdata(s_readdata),
      .o_s_readdatavalid(s_readdatavalid),
      .o_m_read(m_read),
      .o_m_addr(m_addr),
      .i_m_waitrequest(m_waitrequest),
      .i_m_readdata(m_readdata),
      .i_m_readdatavalid(m_readdatavalid),
      .i_flush(flush),
      .o_busy(busy),
      .o_hit_cnt(hit_cnt),
      .o_miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (m_read && !m_waitrequest) m_reads <= m_reads + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (s_waitrequest && n < 1000) begin
         tick();
         n++;
      end
      if (n >= 1000) check("wait_ready_timeout", 1, 0);
   endtask

   task automatic count_busy(input string tag, input int exp);
      int n = 0;
      while (busy && n < 1000) begin
         n++;
         tick();
      end
      check(tag, n, exp);
   endtask

   // One slave read; misses are serviced by the bench acting as the SDRAM
   task automatic read_blk(input string tag, input logic [23:0] a, input bit exp_hit,
                           input logic [31:0] d, input int stall, input int lat, input bit fl);
      wait_ready();
      s_read = 1'b1;
      s_addr = a;
      m_waitrequest = (stall > 0);
      tick();
      s_read = 1'b0;
      if (exp_hit) begin
         check({tag, "_hit_rdv"}, s_readdatavalid, 1);
         check({tag, "_hit_data"}, s_readdata, d);
         check({tag, "_hit_mread"}, m_read, 0);
      end else begin
         check({tag, "_miss_rdv"}, s_readdatavalid, 0);
         check({tag, "_mread"}, m_read, 1);
         check({tag, "_maddr"}, m_addr, {a, 2'b00});
         for (int i = 0; i < stall; i++) begin
            tick();
            check({tag, "_stall_mread"}, m_read, 1);
            check({tag, "_stall_maddr"}, m_addr, {a, 2'b00});
            check({tag, "_stall_swait"}, s_waitrequest, 1);
         end
         m_waitrequest = 1'b0;
         tick();
         check({tag, "_mread_drop"}, m_read, 0);
         for (int i = 0; i < lat; i++) begin
            if (fl && i == 0) flush = 1'b1;
            tick();
            flush = 1'b0;
            check({tag, "_wait_rdv"}, s_readdatavalid, 0);
         end
         m_readdata = d;
         m_readdatavalid = 1'b1;
         tick();
         m_readdatavalid = 1'b0;
         check({tag, "_fill_rdv"}, s_readdatavalid, 1);
         check({tag, "_fill_data"}, s_readdata, d);
         check({tag, "_fill_swait"}, s_waitrequest, fl);
         check({tag, "_fill_busy"}, busy, fl);
      end
   endtask

   initial begin
      int mr0;
      rst = 1'b1;
      s_read = 1'b0;
      s_addr = '0;
      m_waitrequest = 1'b0;
      m_readdata = '0;
      m_readdatavalid = 1'b0;
      flush = 1'b0;
      tick();
      tick();
      check("rst_swait", s_waitrequest, 1);
      rst = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_mread", m_read, 0);
      check("rst_maddr", m_addr, 0);
      check("rst_rdv", s_readdatavalid, 0);
      check("rst_rdata", s_readdata, 0);
      check("rst_hits", hit_cnt, 0);
      check("rst_misses", miss_cnt, 0);
      check("rst_swait_low", s_waitrequest, 0);

      // first miss then hit
      read_blk("a5", 24'h000005, 1'b0, 32'hDEADBEEF, 0, 3, 1'b0);
      read_blk("a5r", 24'h000005, 1'b1, 32'hDEADBEEF, 0, 0, 1'b0);
      check("cnt1_hits", hit_cnt, 1);
      check("cnt1_misses", miss_cnt, 1);

      // fill set 5, evict way 0 on the fifth tag
      read_blk("t1", 24'h000105, 1'b0, 32'h11110105, 0, 1, 1'b0);
      read_blk("t2", 24'h000205, 1'b0, 32'h22220205, 0, 2, 1'b0);
      read_blk("t3", 24'h000305, 1'b0, 32'h33330305, 0, 0, 1'b0);
      read_blk("t4", 24'h000405, 1'b0, 32'h44440405, 0, 1, 1'b0);
      read_blk("t1r", 24'h000105, 1'b1, 32'h11110105, 0, 0, 1'b0);
      read_blk("t4r", 24'h000405, 1'b1, 32'h44440405, 0, 0, 1'b0);
      read_blk("t0m", 24'h000005, 1'b0, 32'h00000A05, 0, 1, 1'b0);
      check("cnt2_hits", hit_cnt, 3);
      check("cnt2_misses", miss_cnt, 6);

      // SDRAM stall during the request phase
      mr0 = m_reads;
      read_blk("stall", 24'h000010, 1'b0, 32'h5A5A0010, 4, 1, 1'b0);
      check("stall_one_read", m_reads - mr0, 1);

      // flush together with a read
      wait_ready();
      s_read = 1'b1;
      s_addr = 24'h000010;
      flush = 1'b1;
      #1;
      check("flush_swait", s_waitrequest, 1);
      tick();
      s_read = 1'b0;
      flush = 1'b0;
      check("flush_no_rdv", s_readdatavalid, 0);
      count_busy("flush_len", 256);
      read_blk("postflush", 24'h000010, 1'b0, 32'h66660010, 0, 1, 1'b0);

      // flush during MISS_WAIT runs after the miss completes
      read_blk("mwflush", 24'h000020, 1'b0, 32'h77770020, 0, 2, 1'b1);
      count_busy("mwflush_len", 256);
      read_blk("mwflush_re", 24'h000020, 1'b0, 32'h88880020, 0, 1, 1'b0);
      check("cnt3_misses", miss_cnt, 10);

      // reset during MISS_WAIT, stale SDRAM data ignored
      wait_ready();
      s_read = 1'b1;
      s_addr = 24'h000030;
      tick();
      s_read = 1'b0;
      tick();
      check("rmw_busy", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rmw_idle", busy, 0);
      check("rmw_mread", m_read, 0);
      m_readdata = 32'hBADBAD30;
      m_readdatavalid = 1'b1;
      tick();
      m_readdatavalid = 1'b0;
      check("rmw_rdv0", s_readdatavalid, 0);
      check("rmw_nobusy", busy, 0);
      tick();
      check("rmw_rdv1", s_readdatavalid, 0);
      read_blk("rmw_re", 24'h000030, 1'b0, 32'h99990030, 0, 1, 1'b0);

      // back-to-back hits and counter saturation
      s_read = 1'b1;
      s_addr = 24'h000030;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("b2b_rdv", s_readdatavalid, 1);
         check("b2b_data", s_readdata, 32'h99990030);
      end
      s_read = 1'b0;
      check("sat_hits", hit_cnt, 15);
      check("sat_misses", miss_cnt, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
